// File: rtl/spi_trans_ctrl.sv
// Sequencer for one SPI master transaction: drives chip select, fetches TX bytes,
// kicks the byte shift engine and writes each received byte back to the RX buffer.
module spi_trans_ctrl #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       send_i,
  input  logic [8:0] n_tx_end_i,
  input  logic       all_1s_i,
  input  logic       all_0s_i,
  input  logic [7:0] tx_data_i,
  input  logic [7:0] rx_data_i,
  input  logic       done_i,
  output logic [8:0] buf_addr_o,
  output logic [7:0] tx_byte_o,
  output logic       start_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_we_o,
  output logic       cs_n_o,
  output logic       clr_send_o,
  output logic [9:0] n_rx_o,
  output logic       busy_o
);

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_LOAD, S_WAIT, S_STORE, S_HOLD, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [7:0] timer_q, timer_d;
  logic [8:0] buf_addr_q, buf_addr_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       start_q, start_d;
  logic       rx_we_q, rx_we_d;
  logic       cs_n_q, cs_n_d;
  logic       clr_send_q, clr_send_d;
  logic [9:0] n_rx_q, n_rx_d;
  logic [9:0] cnt_inc;
  logic [9:0] last_cnt;

  assign cnt_inc  = cnt_q + 10'd1;
  // 10-bit so that n_tx_end_i=511 compares against 512 without wrapping
  assign last_cnt = {1'b0, n_tx_end_i} + 10'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    buf_addr_d = buf_addr_q;
    tx_byte_d  = tx_byte_q;
    rx_byte_d  = rx_byte_q;
    start_d    = 1'b0;
    rx_we_d    = 1'b0;
    cs_n_d     = cs_n_q;
    clr_send_d = 1'b0;
    n_rx_d     = n_rx_q;
    case (state_q)
      S_IDLE: begin
        if (send_i) begin
          state_d = S_SETUP;
          cnt_d   = 10'd0;
          n_rx_d  = 10'd0;
          cs_n_d  = 1'b0;
          timer_d = 8'd0;
        end
      end
      S_SETUP: begin
        if (timer_q == SETUP_LAST) begin
          timer_d    = 8'd0;
          buf_addr_d = cnt_q[8:0];
          state_d    = S_FETCH;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // start is registered alongside tx_byte so the engine sees both in the same cycle
        tx_byte_d = all_1s_i ? 8'hFF : (all_0s_i ? 8'h00 : tx_data_i);
        start_d   = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (done_i) begin
          rx_byte_d = rx_data_i;
          rx_we_d   = 1'b1;
          state_d   = S_STORE;
        end
      end
      S_STORE: begin
        cnt_d  = cnt_inc;
        n_rx_d = cnt_inc;
        if (cnt_inc == last_cnt) begin
          timer_d = 8'd0;
          state_d = S_HOLD;
        end else begin
          buf_addr_d = cnt_inc[8:0];
          state_d    = S_FETCH;
        end
      end
      S_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          timer_d    = 8'd0;
          clr_send_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DONE: begin
        cs_n_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 10'd0;
      timer_q    <= 8'd0;
      buf_addr_q <= 9'd0;
      tx_byte_q  <= 8'd0;
      rx_byte_q  <= 8'd0;
      start_q    <= 1'b0;
      rx_we_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      clr_send_q <= 1'b0;
      n_rx_q     <= 10'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      buf_addr_q <= buf_addr_d;
      tx_byte_q  <= tx_byte_d;
      rx_byte_q  <= rx_byte_d;
      start_q    <= start_d;
      rx_we_q    <= rx_we_d;
      cs_n_q     <= cs_n_d;
      clr_send_q <= clr_send_d;
      n_rx_q     <= n_rx_d;
    end
  end

  assign buf_addr_o = buf_addr_q;
  assign tx_byte_o  = tx_byte_q;
  assign start_o    = start_q;
  assign rx_byte_o  = rx_byte_q;
  assign rx_we_o    = rx_we_q;
  assign cs_n_o     = cs_n_q;
  assign clr_send_o = clr_send_q;
  assign n_rx_o     = n_rx_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_trans_ctrl.sv
// Bench for spi_trans_ctrl: TX/RX buffer and shift-engine models, table-driven
// transactions, hand-written reset/idle corner cases and randomized transactions.
module tb_spi_trans_ctrl;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       send_i = 1'b0;
  logic [8:0] n_tx_end_i = 9'd0;
  logic       all_1s_i = 1'b0;
  logic       all_0s_i = 1'b0;
  logic [7:0] tx_data_i = 8'd0;
  logic [7:0] rx_data_i = 8'd0;
  logic       done_i = 1'b0;
  logic [8:0] buf_addr_o;
  logic [7:0] tx_byte_o;
  logic       start_o;
  logic [7:0] rx_byte_o;
  logic       rx_we_o;
  logic       cs_n_o;
  logic       clr_send_o;
  logic [9:0] n_rx_o;
  logic       busy_o;

  spi_trans_ctrl #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .send_i(send_i), .n_tx_end_i(n_tx_end_i),
    .all_1s_i(all_1s_i), .all_0s_i(all_0s_i), .tx_data_i(tx_data_i),
    .rx_data_i(rx_data_i), .done_i(done_i), .buf_addr_o(buf_addr_o),
    .tx_byte_o(tx_byte_o), .start_o(start_o), .rx_byte_o(rx_byte_o),
    .rx_we_o(rx_we_o), .cs_n_o(cs_n_o), .clr_send_o(clr_send_o),
    .n_rx_o(n_rx_o), .busy_o(busy_o)
  );

  always #50 clk_i = ~clk_i;

  logic [7:0]  tx_mem [512];
  logic [7:0]  rx_pat [512];
  logic [16:0] st_q [$];
  logic [16:0] rw_q [$];
  logic [8:0]  addr_prev = 9'd0;
  int cyc = 0, clr_cnt = 0, cs_bad = 0, first_start = -1, cs_fall = -1, cs_rise = -1;
  int last_we = -1, eng_cnt = 0, eng_dly = 1, eng_idx = 0;
  bit clr_pend = 0, spur_en = 0, force_done = 0, cs_prev = 1;
  int n_vec = 0, n_err = 0;

  typedef struct {
    int         n_end;
    bit         a1;
    bit         a0;
    int         dly;
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] rx_base;
    logic [9:0] exp_nrx;
    logic [8:0] exp_last_addr;
    logic [7:0] exp_last_tx;
  } vec_t;

  // Buffer, engine and control-register models; everything sampled mid-cycle.
  always @(negedge clk_i) begin
    cyc++;
    tx_data_i = tx_mem[addr_prev];
    addr_prev = buf_addr_o;
    if (cs_n_o === busy_o) cs_bad++;
    if (start_o) begin
      st_q.push_back({buf_addr_o, tx_byte_o});
      if (first_start < 0) first_start = cyc;
    end
    if (rx_we_o) begin
      rw_q.push_back({buf_addr_o, rx_byte_o});
      last_we = cyc;
    end
    if (clr_send_o) begin
      clr_cnt++;
      clr_pend = 1;
    end else if (clr_pend) begin
      send_i = 1'b0;
      clr_pend = 0;
    end
    if (!cs_n_o && cs_prev) cs_fall = cyc;
    if (cs_n_o && !cs_prev) cs_rise = cyc;
    cs_prev = cs_n_o;
    done_i = 1'b0;
    if (force_done) begin
      done_i = 1'b1;
      rx_data_i = 8'hEE;
      force_done = 0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        done_i = 1'b1;
        rx_data_i = rx_pat[eng_idx];
        eng_idx++;
      end
    end else if (spur_en && !start_o && $urandom_range(7) == 0) begin
      done_i = 1'b1;
      rx_data_i = 8'($urandom);
    end
    if (start_o) eng_cnt = eng_dly;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_txn(input string name, input int n_end, input bit a1, input bit a0,
                         input int dly, input bit drop);
    int lim, guard, nb, bad;
    bit dropped;
    logic [7:0] exp_b;
    @(posedge clk_i); #1;
    n_tx_end_i = 9'(n_end);
    all_1s_i = a1;
    all_0s_i = a0;
    eng_dly = dly;
    st_q.delete();
    rw_q.delete();
    clr_cnt = 0; cs_bad = 0; first_start = -1; cs_fall = -1; cs_rise = -1;
    last_we = -1; eng_idx = 0;
    send_i = 1'b1;
    lim = (n_end + 1) * (dly + 8) + CS_SETUP + CS_HOLD + 40;
    guard = 0;
    dropped = 0;
    while (!(clr_cnt > 0 && !busy_o) && guard < lim) begin
      @(posedge clk_i); #1;
      guard++;
      if (drop && !dropped && st_q.size() > 0) begin
        send_i = 1'b0;
        dropped = 1;
      end
    end
    n_vec++;
    if (guard >= lim) begin
      n_err++;
      $display("FAIL %s timeout: got %0d cycles, required under %0d", name, guard, lim);
      rst_i = 1'b1; send_i = 1'b0; eng_cnt = 0; clr_pend = 0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      return;
    end
    repeat (3) @(posedge clk_i);
    #1;
    nb = n_end + 1;
    chk({name, " start count"}, st_q.size(), nb);
    bad = -1;
    for (int i = 0; i < st_q.size() && i < nb; i++) begin
      exp_b = a1 ? 8'hFF : (a0 ? 8'h00 : tx_mem[i]);
      if (st_q[i] !== {9'(i), exp_b} && bad < 0) bad = i;
    end
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s tx byte %0d: got addr %0d byte %02h, required addr %0d byte %02h", name,
               bad, st_q[bad][16:8], st_q[bad][7:0], bad,
               a1 ? 8'hFF : (a0 ? 8'h00 : tx_mem[bad]));
    end
    chk({name, " rx write count"}, rw_q.size(), nb);
    bad = -1;
    for (int i = 0; i < rw_q.size() && i < nb; i++)
      if (rw_q[i] !== {9'(i), rx_pat[i]} && bad < 0) bad = i;
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s rx write %0d: got addr %0d data %02h, required addr %0d data %02h", name,
               bad, rw_q[bad][16:8], rw_q[bad][7:0], bad, rx_pat[bad]);
    end
    chk({name, " n_rx"}, n_rx_o, nb);
    chk({name, " clr_send pulses"}, clr_cnt, 1);
    chk({name, " cs_n vs busy"}, cs_bad, 0);
    chk({name, " cs lead"}, first_start - cs_fall, CS_SETUP + 2);
    chk({name, " cs tail"}, cs_rise - last_we, CS_HOLD + 2);
    chk({name, " idle after"}, busy_o, 0);
    $display("txn %s: n_end=%0d starts=%0d rx_writes=%0d n_rx=%0d cycles=%0d",
             name, n_end, st_q.size(), rw_q.size(), n_rx_o, guard);
  endtask

  vec_t vecs [5];

  initial begin
    logic [16:0] last_s;
    int guard;
    vecs[0] = '{0,   0, 0, 8, 8'hA5, 8'h00, 8'h3C, 10'd1,   9'd0,   8'hA5};
    vecs[1] = '{3,   0, 0, 3, 8'h11, 8'h11, 8'h80, 10'd4,   9'd3,   8'h44};
    vecs[2] = '{1,   1, 1, 2, 8'h5A, 8'h01, 8'h20, 10'd2,   9'd1,   8'hFF};
    vecs[3] = '{1,   0, 1, 2, 8'h5A, 8'h01, 8'h30, 10'd2,   9'd1,   8'h00};
    vecs[4] = '{511, 0, 0, 1, 8'h00, 8'h01, 8'h00, 10'd512, 9'd511, 8'hFF};

    repeat (3) @(posedge clk_i);
    #1;
    chk("reset cs_n", cs_n_o, 1);
    chk("reset busy", busy_o, 0);
    chk("reset start", start_o, 0);
    chk("reset rx_we", rx_we_o, 0);
    chk("reset clr_send", clr_send_o, 0);
    chk("reset buf_addr", buf_addr_o, 0);
    chk("reset tx_byte", tx_byte_o, 0);
    chk("reset rx_byte", rx_byte_o, 0);
    chk("reset n_rx", n_rx_o, 0);
    rst_i = 1'b0;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 512; i++) begin
        tx_mem[i] = vecs[v].base + 8'(int'(vecs[v].step) * i);
        rx_pat[i] = vecs[v].rx_base + 8'(i);
      end
      run_txn($sformatf("table%0d", v), vecs[v].n_end, vecs[v].a1, vecs[v].a0, vecs[v].dly, 0);
      last_s = (st_q.size() > 0) ? st_q[st_q.size() - 1] : 17'h1FFFF;
      chk($sformatf("table%0d n_rx", v), n_rx_o, vecs[v].exp_nrx);
      chk($sformatf("table%0d last addr", v), last_s[16:8], vecs[v].exp_last_addr);
      chk($sformatf("table%0d last tx", v), last_s[7:0], vecs[v].exp_last_tx);
    end

    // reset in WAIT of byte 2 aborts at once, then a fresh send restarts at address 0
    for (int i = 0; i < 512; i++) begin
      tx_mem[i] = 8'($urandom);
      rx_pat[i] = 8'($urandom);
    end
    @(posedge clk_i); #1;
    n_tx_end_i = 9'd5; all_1s_i = 1'b0; all_0s_i = 1'b0; eng_dly = 8;
    st_q.delete(); rw_q.delete(); eng_idx = 0; clr_cnt = 0;
    send_i = 1'b1;
    guard = 0;
    while (st_q.size() < 3 && guard < 200) begin
      @(posedge clk_i); #1;
      guard++;
    end
    chk("abort reached byte 2", st_q.size(), 3);
    @(posedge clk_i); #20;
    chk("abort n_rx before reset", n_rx_o, 2);
    rst_i = 1'b1; send_i = 1'b0; eng_cnt = 0; clr_pend = 0;
    #1;
    chk("abort cs_n", cs_n_o, 1);
    chk("abort busy", busy_o, 0);
    chk("abort n_rx", n_rx_o, 0);
    chk("abort clr_send", clr_send_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("abort no clr_send", clr_cnt, 0);
    run_txn("restart", 1, 0, 0, 3, 0);

    // done_i while idle is ignored; dropping send_i mid-transaction does not abort
    st_q.delete();
    @(posedge clk_i); #1;
    force_done = 1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("idle done busy", busy_o, 0);
    chk("idle done starts", st_q.size(), 0);
    chk("idle done n_rx", n_rx_o, 2);
    run_txn("send drop", 3, 0, 0, 4, 1);

    spur_en = 1;
    for (int t = 0; t < 25; t++) begin
      int n_end;
      n_end = ($urandom_range(9) == 0) ? int'($urandom_range(100)) : int'($urandom_range(12));
      for (int i = 0; i < 512; i++) begin
        tx_mem[i] = 8'($urandom);
        rx_pat[i] = 8'($urandom);
      end
      run_txn($sformatf("rand%0d", t), n_end, $urandom_range(3) == 0, $urandom_range(3) == 0,
              int'($urandom_range(1, 5)), $urandom_range(1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
